// File: rtl/ser8_tx.sv
// Parallel-to-serial transmitter: accepts one word through valid/ready, shifts it out one bit per clock, then pulses done.
// Optional even-parity trailer bit is built when PARITY_EN is defined.
module ser8_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    localparam int CNT_W = $clog2(WIDTH);

`ifdef PARITY_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2, S_PAR = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;
`endif

    // Handshake: a word transfers on a rising edge where load_valid && load_ready;
    // load_ready is high only in IDLE, and load_valid seen in any other state is ignored.
    state_t             state, state_nxt;
    logic [WIDTH-1:0]   shreg;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               last_bit;
    logic               first_bit;
    logic               next_bit;
    logic               sout_d, sout_valid_d, busy_d, done_d;
`ifdef PARITY_EN
    logic               parity;
`endif

    assign accept     = (state == S_IDLE) && load_valid;
    assign last_bit   = (cnt == CNT_W'(WIDTH - 1));
    assign load_ready = (state == S_IDLE);
    assign state_dbg  = state;

    // The first bit comes straight from din so it can be registered on the accept edge.
    assign first_bit = MSB_FIRST ? din[WIDTH-1] : din[0];
    assign next_bit  = MSB_FIRST ? shreg[WIDTH-2] : shreg[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (load_valid) state_nxt = S_SHIFT;
`ifdef PARITY_EN
            S_SHIFT: if (last_bit) state_nxt = S_PAR;
            S_PAR:   state_nxt = S_DONE;
`else
            S_SHIFT: if (last_bit) state_nxt = S_DONE;
`endif
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are the registered image of what the next state presents.
    always_comb begin
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        case (state_nxt)
            S_SHIFT: begin
                sout_valid_d = 1'b1;
                busy_d       = 1'b1;
                sout_d       = (state == S_IDLE) ? first_bit : next_bit;
            end
`ifdef PARITY_EN
            S_PAR: begin
                sout_valid_d = 1'b1;
                busy_d       = 1'b1;
                sout_d       = parity;
            end
`endif
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            sout       <= sout_d;
            sout_valid <= sout_valid_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    // Counter tracks the index of the bit on sout and stops at WIDTH-1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            shreg <= din;
            cnt   <= '0;
        end else if (state == S_SHIFT && !last_bit) begin
            shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
            cnt   <= cnt + CNT_W'(1);
        end
    end

`ifdef PARITY_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            parity <= 1'b0;
        end else if (accept) begin
            parity <= ^din;
        end
    end
`endif

endmodule

// File: tb/tb_ser8_tx.sv
// Bench for ser8_tx: MSB-first and LSB-first instances share stimulus; expected serial bits are queued at load time.
module tb_ser8_tx;
    localparam int W = 8;
`ifdef PARITY_EN
    localparam int NV = W + 1;
`else
    localparam int NV = W;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] din = '0;
    logic         load_valid = 1'b0;

    logic       m_ready, m_sout, m_valid, m_busy, m_done;
    logic [1:0] m_state;
    logic       l_ready, l_sout, l_valid, l_busy, l_done;
    logic [1:0] l_state;

    logic exp_m[$];
    logic exp_l[$];
    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    ser8_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clock(clock), .reset(reset), .din(din), .load_valid(load_valid),
        .load_ready(m_ready), .sout(m_sout), .sout_valid(m_valid),
        .busy(m_busy), .done(m_done), .state_dbg(m_state)
    );

    ser8_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clock(clock), .reset(reset), .din(din), .load_valid(load_valid),
        .load_ready(l_ready), .sout(l_sout), .sout_valid(l_valid),
        .busy(l_busy), .done(l_done), .state_dbg(l_state)
    );

    task automatic start_word(input logic [W-1:0] w, input bit hold, input logic [W-1:0] nxt);
        int n = 0;
        while (m_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL start_timeout load_ready=%b expected=1", m_ready);
        end
        din = w;
        load_valid = 1'b1;
        for (int i = W - 1; i >= 0; i--) exp_m.push_back(w[i]);
        for (int i = 0; i < W; i++) exp_l.push_back(w[i]);
`ifdef PARITY_EN
        exp_m.push_back(^w);
        exp_l.push_back(^w);
`endif
        @(posedge clock);
        #1;
        if (hold) din = nxt;
        else load_valid = 1'b0;
    endtask

    task automatic check_frame(input int nbits);
        logic em, el;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clock);
            checks++;
            if (m_valid !== 1'b1 || l_valid !== 1'b1 || m_busy !== 1'b1 || l_busy !== 1'b1 ||
                m_done !== 1'b0 || l_done !== 1'b0 || m_ready !== 1'b0 || l_ready !== 1'b0) begin
                failures++;
                $display("FAIL frame_ctl bit=%0d valid=%b%b busy=%b%b done=%b%b ready=%b%b expected valid=11 busy=11 done=00 ready=00",
                         i, m_valid, l_valid, m_busy, l_busy, m_done, l_done, m_ready, l_ready);
            end
            em = (exp_m.size() > 0) ? exp_m.pop_front() : 1'bx;
            el = (exp_l.size() > 0) ? exp_l.pop_front() : 1'bx;
            checks++;
            if (m_sout !== em) begin
                failures++;
                $display("FAIL msb_bit idx=%0d got=%b expected=%b", i, m_sout, em);
            end
            checks++;
            if (l_sout !== el) begin
                failures++;
                $display("FAIL lsb_bit idx=%0d got=%b expected=%b", i, l_sout, el);
            end
        end
        @(negedge clock);
        checks++;
        if (m_done !== 1'b1 || l_done !== 1'b1 || m_valid !== 1'b0 || l_valid !== 1'b0 ||
            m_busy !== 1'b0 || l_busy !== 1'b0 || m_sout !== 1'b0 || l_sout !== 1'b0) begin
            failures++;
            $display("FAIL done_cycle done=%b%b valid=%b%b busy=%b%b sout=%b%b expected done=11 others=0",
                     m_done, l_done, m_valid, l_valid, m_busy, l_busy, m_sout, l_sout);
        end
        @(negedge clock);
        checks++;
        if (m_done !== 1'b0 || l_done !== 1'b0 || m_ready !== 1'b1 || l_ready !== 1'b1 ||
            m_valid !== 1'b0 || l_valid !== 1'b0) begin
            failures++;
            $display("FAIL back_to_idle done=%b%b ready=%b%b valid=%b%b expected done=00 ready=11 valid=00",
                     m_done, l_done, m_ready, l_ready, m_valid, l_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        load_valid = 1'b1;
        din = 8'hFF;
        repeat (4) begin
            @(negedge clock);
            checks++;
            if ({m_sout, m_valid, m_busy, m_done, l_sout, l_valid, l_busy, l_done} !== 8'h00 ||
                m_state !== 2'd0 || l_state !== 2'd0) begin
                failures++;
                $display("FAIL reset_outputs got=%b state=%0d/%0d expected=00000000 state=0/0",
                         {m_sout, m_valid, m_busy, m_done, l_sout, l_valid, l_busy, l_done}, m_state, l_state);
            end
        end
        load_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (m_ready !== 1'b1 || l_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b%b expected=11", m_ready, l_ready);
        end
    endtask

    task automatic test_bit_order();
        start_word(8'b1001_1000, 1'b0, '0);
        check_frame(NV);
    endtask

    task automatic test_load_ignored_while_busy();
        start_word(8'hE7, 1'b1, 8'h00);
        check_frame(NV);
        start_word(8'h00, 1'b0, '0);
        check_frame(NV);
    endtask

    task automatic test_reset_midframe();
        logic em, el;
        start_word(8'hFC, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            em = exp_m.pop_front();
            el = exp_l.pop_front();
            checks++;
            if (m_sout !== em || l_sout !== el || m_valid !== 1'b1) begin
                failures++;
                $display("FAIL midframe_bit idx=%0d got=%b%b valid=%b expected=%b%b valid=1",
                         i, m_sout, l_sout, m_valid, em, el);
            end
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({m_sout, m_valid, m_busy, m_done, l_sout, l_valid, l_busy, l_done} !== 8'h00 ||
            m_ready !== 1'b1 || m_state !== 2'd0) begin
            failures++;
            $display("FAIL async_abort got=%b ready=%b state=%0d expected=00000000 ready=1 state=0",
                     {m_sout, m_valid, m_busy, m_done, l_sout, l_valid, l_busy, l_done}, m_ready, m_state);
        end
        exp_m.delete();
        exp_l.delete();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clock);
            checks++;
            if (m_done !== 1'b0 || l_done !== 1'b0 || m_valid !== 1'b0 || m_ready !== 1'b1) begin
                failures++;
                $display("FAIL no_done_after_abort done=%b%b valid=%b ready=%b expected done=00 valid=0 ready=1",
                         m_done, l_done, m_valid, m_ready);
            end
        end
        start_word(8'h01, 1'b0, '0);
        check_frame(NV);
    endtask

    task automatic test_parity_words();
        start_word(8'hE0, 1'b0, '0);
        check_frame(NV);
        start_word(8'h0F, 1'b0, '0);
        check_frame(NV);
    endtask

    task automatic test_random_words();
        logic [W-1:0] w;
        for (int k = 0; k < 4; k++) begin
            w = W'($urandom_range(0, 255));
            start_word(w, 1'b0, '0);
            check_frame(NV);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bit_order();
        test_load_ignored_while_busy();
        test_reset_midframe();
        test_parity_words();
        test_random_words();
        checks++;
        if (exp_m.size() != 0 || exp_l.size() != 0) begin
            failures++;
            $display("FAIL leftover_expected got=%0d/%0d expected=0/0", exp_m.size(), exp_l.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
